axil_regfile_slave: RTL and testbench

//  Parametrised AXI-lite register-file slave that terminates the HPS lightweight AXI master in the FPGA fabric.

---
 rtl/axil_regfile_if.sv | 42 ++++
 rtl/axil_regfile_slave.sv | 236 +++++++++++++++++++++++
 tb/tb_axil_regfile_slave.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_regfile_if.sv
// AXI-lite bus bundle for the register-file slave, carrying native ID echo and RLAST.
interface axil_regfile_if #(
   parameter int ADDR_W = 21,
   parameter int ID_W   = 12
);
   logic              awvalid;
   logic              awready;
   logic [ADDR_W-1:0] awaddr;
   logic [ID_W-1:0]   awid;
   logic [2:0]        awprot;
   logic              wvalid;
   logic              wready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              bvalid;
   logic              bready;
   logic [1:0]        bresp;
   logic [ID_W-1:0]   bid;
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [ID_W-1:0]   arid;
   logic [2:0]        arprot;
   logic              rvalid;
   logic              rready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic [ID_W-1:0]   rid;
   logic              rlast;

   modport slave (
      input  awvalid, awaddr, awid, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arid, arprot, rready,
      output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid, rlast
   );

   modport master (
      output awvalid, awaddr, awid, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arid, arprot, rready,
      input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid, rlast
   );
endinterface

// File: rtl/axil_regfile_slave.sv
// AXI-lite register-file slave: N_RW control words, N_RO status words, SLVERR on unmapped access.
// Optional AXIL_STATS_EN adds write/read handshake counters as two extra read-only words.
module axil_regfile_slave #(
   parameter int          ADDR_W   = 21,
   parameter int          ID_W     = 12,
   parameter int          N_RW     = 8,
   parameter int          N_RO     = 8,
   parameter logic [31:0] RW_RESET = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   axil_regfile_if.slave        s_axil,
   output logic [N_RW*32-1:0]   reg_rw_o,
   input  logic [N_RO*32-1:0]   reg_ro_i,
   output logic [N_RW-1:0]      wr_pulse_o
);
   localparam int         IDX_W       = ADDR_W - 2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic { W_IDLE, W_RESP } w_state_e;
   typedef enum logic { R_IDLE, R_DATA } r_state_e;

   w_state_e          w_state_q, w_state_d;
   logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
   logic [ID_W-1:0]   aw_id_q, aw_id_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic [ID_W-1:0]   bid_q, bid_d;
   logic [N_RW-1:0]   pulse_q, pulse_d;
   logic [31:0]       rw_q [N_RW];
   logic [31:0]       rw_d [N_RW];
   logic              wr_ok;

   r_state_e          r_state_q, r_state_d;
   logic              rvalid_q, rvalid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic [IDX_W-1:0]  ar_idx;
   logic              rd_hit;
   logic [31:0]       rd_word;

   logic              awready, wready, arready;
   logic              unused_bits;

`ifdef AXIL_STATS_EN
   logic [31:0]       wr_cnt_q, rd_cnt_q;
`endif

   // NOTE: readies are gated by rst so the bus sees no acceptance while reset is held.
   assign awready = !rst && (w_state_q == W_IDLE) && !aw_got_q;
   assign wready  = !rst && (w_state_q == W_IDLE) && !w_got_q;
   assign arready = !rst && (r_state_q == R_IDLE);
   assign unused_bits = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr[1:0], s_axil.araddr[1:0]};

   // NOTE: next-state logic is combinational with every *_d defaulted first, so no latches form.
   always_comb begin
      w_state_d = w_state_q;
      aw_got_d  = aw_got_q;
      aw_idx_d  = aw_idx_q;
      aw_id_d   = aw_id_q;
      w_got_d   = w_got_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      bid_d     = bid_q;
      pulse_d   = '0;
      rw_d      = rw_q;
      wr_ok     = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (s_axil.awvalid && awready) begin
               aw_got_d = 1'b1;
               aw_idx_d = s_axil.awaddr[ADDR_W-1:2];
               aw_id_d  = s_axil.awid;
            end
            if (s_axil.wvalid && wready) begin
               w_got_d = 1'b1;
               wdata_d = s_axil.wdata;
               wstrb_d = s_axil.wstrb;
            end
            if (aw_got_d && w_got_d) begin
               for (int k = 0; k < N_RW; k++) begin
                  if (aw_idx_d == IDX_W'(k)) begin
                     wr_ok      = 1'b1;
                     pulse_d[k] = 1'b1;
                     for (int b = 0; b < 4; b++)
                        if (wstrb_d[b]) rw_d[k][8*b +: 8] = wdata_d[8*b +: 8];
                  end
               end
               bvalid_d  = 1'b1;
               bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
               bid_d     = aw_id_d;
               aw_got_d  = 1'b0;
               w_got_d   = 1'b0;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axil.bready) begin
               bvalid_d  = 1'b0;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      ar_idx  = s_axil.araddr[ADDR_W-1:2];
      rd_hit  = 1'b0;
      rd_word = '0;
      for (int k = 0; k < N_RW; k++)
         if (ar_idx == IDX_W'(k)) begin
            rd_hit  = 1'b1;
            rd_word = rw_q[k];
         end
      for (int k = 0; k < N_RO; k++)
         if (ar_idx == IDX_W'(N_RW + k)) begin
            rd_hit  = 1'b1;
            rd_word = reg_ro_i[32*k +: 32];
         end
`ifdef AXIL_STATS_EN
      if (ar_idx == IDX_W'(N_RW + N_RO)) begin
         rd_hit  = 1'b1;
         rd_word = wr_cnt_q;
      end
      if (ar_idx == IDX_W'(N_RW + N_RO + 1)) begin
         rd_hit  = 1'b1;
         rd_word = rd_cnt_q;
      end
`endif
   end

   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rid_d     = rid_q;
      case (r_state_q)
         R_IDLE: begin
            if (s_axil.arvalid && arready) begin
               rvalid_d  = 1'b1;
               rdata_d   = rd_word;
               rresp_d   = rd_hit ? RESP_OKAY : RESP_SLVERR;
               rid_d     = s_axil.arid;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (s_axil.rready) begin
               rvalid_d  = 1'b0;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // NOTE: the register array is small and software-visible, so every word is reset, unlike a RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         aw_got_q  <= 1'b0;
         aw_idx_q  <= '0;
         aw_id_q   <= '0;
         w_got_q   <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         bid_q     <= '0;
         pulse_q   <= '0;
         for (int k = 0; k < N_RW; k++) rw_q[k] <= RW_RESET;
         r_state_q <= R_IDLE;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         rid_q     <= '0;
      end else begin
         w_state_q <= w_state_d;
         aw_got_q  <= aw_got_d;
         aw_idx_q  <= aw_idx_d;
         aw_id_q   <= aw_id_d;
         w_got_q   <= w_got_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         bid_q     <= bid_d;
         pulse_q   <= pulse_d;
         rw_q      <= rw_d;
         r_state_q <= r_state_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rid_q     <= rid_d;
      end
   end

`ifdef AXIL_STATS_EN
   // Counters wrap naturally and include SLVERR responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         if (bvalid_q && s_axil.bready) wr_cnt_q <= wr_cnt_q + 32'd1;
         if (rvalid_q && s_axil.rready) rd_cnt_q <= rd_cnt_q + 32'd1;
      end
   end
`endif

   for (genvar k = 0; k < N_RW; k++) begin : g_rw_out
      assign reg_rw_o[32*k +: 32] = rw_q[k];
   end

   assign wr_pulse_o     = pulse_q;
   assign s_axil.awready = awready;
   assign s_axil.wready  = wready;
   assign s_axil.bvalid  = bvalid_q;
   assign s_axil.bresp   = bresp_q;
   assign s_axil.bid     = bid_q;
   assign s_axil.arready = arready;
   assign s_axil.rvalid  = rvalid_q;
   assign s_axil.rdata   = rdata_q;
   assign s_axil.rresp   = rresp_q;
   assign s_axil.rid     = rid_q;
   assign s_axil.rlast   = rvalid_q;
endmodule

// File: tb/tb_axil_regfile_slave.sv
// Directed bench for axil_regfile_slave: reset, RW/RO/unmapped access, handshake ordering, stats words.
module tb_axil_regfile_slave;
   localparam int ADDR_W = 21;
   localparam int ID_W   = 12;
   localparam int N_RW   = 8;
   localparam int N_RO   = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N_RW*32-1:0]   reg_rw;
   logic [N_RO*32-1:0]   reg_ro;
   logic [N_RW-1:0]      wr_pulse;
   int                   checks = 0;
   int                   errors = 0;
   logic [31:0]          rd_data;
   logic [1:0]           rd_resp;

   always #5 clk = ~clk;

   axil_regfile_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

   axil_regfile_slave #(
      .ADDR_W(ADDR_W), .ID_W(ID_W), .N_RW(N_RW), .N_RO(N_RO), .RW_RESET(32'h0000_0000)
   ) dut (
      .clk(clk), .rst(rst), .s_axil(bus),
      .reg_rw_o(reg_rw), .reg_ro_i(reg_ro), .wr_pulse_o(wr_pulse)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rw_word(input int k);
      return reg_rw[32*k +: 32];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_write(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                             input logic [31:0] data, input logic [3:0] strb);
      bus.awvalid = 1'b1; bus.awaddr = addr; bus.awid = id;
      bus.wvalid  = 1'b1; bus.wdata  = data; bus.wstrb = strb;
      for (int i = 0; i < 20 && !(bus.awready && bus.wready); i++) tick();
      check("write_ready", 32'(bus.awready && bus.wready), 32'd1);
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      check("bvalid_after_write", 32'(bus.bvalid), 32'd1);
   endtask

   task automatic accept_b();
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      check("bvalid_cleared", 32'(bus.bvalid), 32'd0);
   endtask

   task automatic send_read(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id);
      bus.arvalid = 1'b1; bus.araddr = addr; bus.arid = id;
      for (int i = 0; i < 20 && !bus.arready; i++) tick();
      check("read_ready", 32'(bus.arready), 32'd1);
      tick();
      bus.arvalid = 1'b0;
      check("rvalid_after_ar", 32'(bus.rvalid), 32'd1);
      check("rid_echo", 32'(bus.rid), 32'(id));
      check("rlast", 32'(bus.rlast), 32'd1);
      rd_data = bus.rdata;
      rd_resp = bus.rresp;
   endtask

   task automatic accept_r();
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
      check("rvalid_cleared", 32'(bus.rvalid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.awvalid = 1'b0; bus.awaddr = '0; bus.awid = '0; bus.awprot = '0;
      bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0; bus.bready = 1'b0;
      bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arprot = '0; bus.rready = 1'b0;
      for (int k = 0; k < N_RO; k++) reg_ro[32*k +: 32] = 32'hC0DE_0000 + 32'(k);
      rst = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_awready", 32'(bus.awready), 32'd0);
      check("rst_wready", 32'(bus.wready), 32'd0);
      check("rst_arready", 32'(bus.arready), 32'd0);
      check("rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_pulse", 32'(wr_pulse), 32'd0);
      check("rst_reg0", rw_word(0), 32'h0000_0000);
      rst = 1'b0;
      tick();
      check("idle_awready", 32'(bus.awready), 32'd1);
      check("idle_arready", 32'(bus.arready), 32'd1);

      // Read idx0 after reset
      send_read(21'h0, 12'h123);
      check("rd0_data", rd_data, 32'h0000_0000);
      check("rd0_resp", 32'(rd_resp), 32'd0);
      accept_r();

      // AW first, W three cycles later
      bus.awvalid = 1'b1; bus.awaddr = 21'h4; bus.awid = 12'hABC;
      tick();
      bus.awvalid = 1'b0;
      tick();
      tick();
      check("split_awready", 32'(bus.awready), 32'd0);
      check("split_wready", 32'(bus.wready), 32'd1);
      check("split_no_b", 32'(bus.bvalid), 32'd0);
      bus.wvalid = 1'b1; bus.wdata = 32'hA5A5_1234; bus.wstrb = 4'b0011;
      tick();
      bus.wvalid = 1'b0;
      check("split_bvalid", 32'(bus.bvalid), 32'd1);
      check("split_bresp", 32'(bus.bresp), 32'd0);
      check("split_bid", 32'(bus.bid), 32'h0ABC);
      check("split_pulse", 32'(wr_pulse), 32'h02);
      check("split_reg1", rw_word(1), 32'h0000_1234);
      tick();
      check("pulse_one_cycle", 32'(wr_pulse), 32'd0);
      check("bvalid_held", 32'(bus.bvalid), 32'd1);
      accept_b();

      // wstrb = 0 to an RW register
      send_write(21'h4, 12'h001, 32'hFFFF_FFFF, 4'b0000);
      check("strb0_bresp", 32'(bus.bresp), 32'd0);
      check("strb0_pulse", 32'(wr_pulse), 32'h02);
      check("strb0_reg1", rw_word(1), 32'h0000_1234);
      accept_b();

      // Write then read first and last RO words
      send_write(21'h20, 12'h002, 32'hDEAD_BEEF, 4'b1111);
      check("ro_wr_bresp", 32'(bus.bresp), 32'd2);
      check("ro_wr_pulse", 32'(wr_pulse), 32'd0);
      check("ro_wr_bid", 32'(bus.bid), 32'h002);
      accept_b();
      send_read(21'h20, 12'h021);
      check("ro8_data", rd_data, 32'hC0DE_0000);
      check("ro8_resp", 32'(rd_resp), 32'd0);
      accept_r();
      send_read(21'h3C, 12'h022);
      check("ro15_data", rd_data, 32'hC0DE_0007);
      accept_r();

      // Unmapped idx 18 with response back-pressure
      send_write(21'h48, 12'h033, 32'h1234_5678, 4'b1111);
      check("unm_wr_pulse", 32'(wr_pulse), 32'd0);
      repeat (5) tick();
      check("unm_bvalid_held", 32'(bus.bvalid), 32'd1);
      check("unm_bresp_held", 32'(bus.bresp), 32'd2);
      check("unm_bid_held", 32'(bus.bid), 32'h033);
      check("unm_reg0_untouched", rw_word(0), 32'h0000_0000);
      accept_b();
      send_read(21'h48, 12'h044);
      repeat (5) tick();
      check("unm_rvalid_held", 32'(bus.rvalid), 32'd1);
      check("unm_rresp_held", 32'(bus.rresp), 32'd2);
      check("unm_rdata_held", bus.rdata, 32'd0);
      check("unm_rid_held", 32'(bus.rid), 32'h044);
      accept_r();

      // Same-cycle write commit and read of reg2
      send_write(21'h8, 12'h005, 32'h0000_0011, 4'b1111);
      accept_b();
      bus.awvalid = 1'b1; bus.awaddr = 21'h8; bus.awid = 12'h006;
      bus.wvalid  = 1'b1; bus.wdata  = 32'h0000_0022; bus.wstrb = 4'b1111;
      bus.arvalid = 1'b1; bus.araddr = 21'h8; bus.arid = 12'h007;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      check("race_rvalid", 32'(bus.rvalid), 32'd1);
      check("race_rdata_old", bus.rdata, 32'h0000_0011);
      check("race_bvalid", 32'(bus.bvalid), 32'd1);
      check("race_reg2_new", rw_word(2), 32'h0000_0022);
      accept_b();
      accept_r();
      send_read(21'h00000B, 12'h008);
      check("reg2_readback", rd_data, 32'h0000_0022);
      accept_r();

      // Asynchronous reset aborts a half-accepted write
      bus.awvalid = 1'b1; bus.awaddr = 21'hC; bus.awid = 12'h009;
      tick();
      bus.awvalid = 1'b0;
      rst = 1'b1;
      #1;
      check("abort_awready", 32'(bus.awready), 32'd0);
      check("abort_reg1_reset", rw_word(1), 32'h0000_0000);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("abort_no_b", 32'(bus.bvalid), 32'd0);
      check("abort_awready_back", 32'(bus.awready), 32'd1);
      check("abort_wready_back", 32'(bus.wready), 32'd1);

`ifdef AXIL_STATS_EN
      send_write(21'h0, 12'h010, 32'h1111_1111, 4'b1111);
      accept_b();
      send_write(21'h4, 12'h011, 32'h2222_2222, 4'b1111);
      accept_b();
      send_write(21'h48, 12'h012, 32'h3333_3333, 4'b1111);
      accept_b();
      send_read(21'h0, 12'h013);
      accept_r();
      send_read(21'h48, 12'h014);
      check("stats_slverr_read", 32'(rd_resp), 32'd2);
      accept_r();
      send_read(21'h44, 12'h015);
      check("stats_rd_cnt", rd_data, 32'd2);
      check("stats_rd_cnt_resp", 32'(rd_resp), 32'd0);
      accept_r();
      send_read(21'h40, 12'h016);
      check("stats_wr_cnt", rd_data, 32'd3);
      accept_r();
      send_write(21'h40, 12'h017, 32'hFFFF_FFFF, 4'b1111);
      check("stats_wr_slverr", 32'(bus.bresp), 32'd2);
      accept_b();
`else
      send_read(21'h40, 12'h015);
      check("nostats_rd16_resp", 32'(rd_resp), 32'd2);
      check("nostats_rd16_data", rd_data, 32'd0);
      accept_r();
      send_read(21'h44, 12'h016);
      check("nostats_rd17_resp", 32'(rd_resp), 32'd2);
      accept_r();
      send_write(21'h44, 12'h017, 32'hFFFF_FFFF, 4'b1111);
      check("nostats_wr17_bresp", 32'(bus.bresp), 32'd2);
      accept_b();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
